// File: rtl/tl_a_channel_arbiter.sv
// Two-requester TileLink-UH arbiter: round-robin A grant locked across Put bursts,
// D routing by source tag, per-requester outstanding limit. Optional logging: TL_ARB_MONITOR_EN.
module tl_a_channel_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int SRC_W           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0_a_valid,
    output logic                  r0_a_ready,
    input  logic [2:0]            r0_a_bits_opcode,
    input  logic [2:0]            r0_a_bits_param,
    input  logic [3:0]            r0_a_bits_size,
    input  logic [SRC_W-1:0]      r0_a_bits_source,
    input  logic [ADDR_W-1:0]     r0_a_bits_address,
    input  logic [DATA_W/8-1:0]   r0_a_bits_mask,
    input  logic [DATA_W-1:0]     r0_a_bits_data,
    output logic                  r0_d_valid,
    input  logic                  r0_d_ready,
    output logic [2:0]            r0_d_bits_opcode,
    output logic [1:0]            r0_d_bits_param,
    output logic [3:0]            r0_d_bits_size,
    output logic [SRC_W-1:0]      r0_d_bits_source,
    output logic [1:0]            r0_d_bits_sink,
    output logic                  r0_d_bits_denied,
    output logic                  r0_d_bits_corrupt,
    output logic [DATA_W-1:0]     r0_d_bits_data,
    input  logic                  r1_a_valid,
    output logic                  r1_a_ready,
    input  logic [2:0]            r1_a_bits_opcode,
    input  logic [2:0]            r1_a_bits_param,
    input  logic [3:0]            r1_a_bits_size,
    input  logic [SRC_W-1:0]      r1_a_bits_source,
    input  logic [ADDR_W-1:0]     r1_a_bits_address,
    input  logic [DATA_W/8-1:0]   r1_a_bits_mask,
    input  logic [DATA_W-1:0]     r1_a_bits_data,
    output logic                  r1_d_valid,
    input  logic                  r1_d_ready,
    output logic [2:0]            r1_d_bits_opcode,
    output logic [1:0]            r1_d_bits_param,
    output logic [3:0]            r1_d_bits_size,
    output logic [SRC_W-1:0]      r1_d_bits_source,
    output logic [1:0]            r1_d_bits_sink,
    output logic                  r1_d_bits_denied,
    output logic                  r1_d_bits_corrupt,
    output logic [DATA_W-1:0]     r1_d_bits_data,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [2:0]            a_bits_opcode,
    output logic [2:0]            a_bits_param,
    output logic [3:0]            a_bits_size,
    output logic [SRC_W:0]        a_bits_source,
    output logic [ADDR_W-1:0]     a_bits_address,
    output logic [DATA_W/8-1:0]   a_bits_mask,
    output logic [DATA_W-1:0]     a_bits_data,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [2:0]            d_bits_opcode,
    input  logic [1:0]            d_bits_param,
    input  logic [3:0]            d_bits_size,
    input  logic [SRC_W:0]        d_bits_source,
    input  logic [1:0]            d_bits_sink,
    input  logic                  d_bits_denied,
    input  logic                  d_bits_corrupt,
    input  logic [DATA_W-1:0]     d_bits_data,
    output logic [1:0]            gnt
);
    localparam int MASK_W    = DATA_W / 8;
    localparam int OUT_W     = 4;
    localparam int BCNT_W    = 16;
    localparam logic [3:0] BEAT_SIZE = 4'($clog2(MASK_W));

    typedef enum logic {ST_IDLE, ST_LOCK} state_e;

    logic                req_valid   [2];
    logic [2:0]          req_opcode  [2];
    logic [2:0]          req_param   [2];
    logic [3:0]          req_size    [2];
    logic [SRC_W-1:0]    req_source  [2];
    logic [ADDR_W-1:0]   req_address [2];
    logic [MASK_W-1:0]   req_mask    [2];
    logic [DATA_W-1:0]   req_data    [2];
    logic                req_ready   [2];
    logic                rsp_valid   [2];
    logic                rsp_ready   [2];
    logic                elig        [2];

    assign req_valid   = '{r0_a_valid, r1_a_valid};
    assign req_opcode  = '{r0_a_bits_opcode, r1_a_bits_opcode};
    assign req_param   = '{r0_a_bits_param, r1_a_bits_param};
    assign req_size    = '{r0_a_bits_size, r1_a_bits_size};
    assign req_source  = '{r0_a_bits_source, r1_a_bits_source};
    assign req_address = '{r0_a_bits_address, r1_a_bits_address};
    assign req_mask    = '{r0_a_bits_mask, r1_a_bits_mask};
    assign req_data    = '{r0_a_bits_data, r1_a_bits_data};
    assign rsp_ready   = '{r0_d_ready, r1_d_ready};
    assign r0_a_ready  = req_ready[0];
    assign r1_a_ready  = req_ready[1];
    assign r0_d_valid  = rsp_valid[0];
    assign r1_d_valid  = rsp_valid[1];

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic                lock_q, lock_d;
    logic [BCNT_W-1:0]   beat_q, beat_d;
    logic                sel, sel_valid, a_fire, a_first_fire, a_multi;
    logic [BCNT_W-1:0]   a_beats_m1;

    // While locked the owner keeps the bus even if the other side is eligible.
    always_comb begin
        sel       = 1'b0;
        sel_valid = 1'b0;
        if (state_q == ST_LOCK) begin
            sel       = lock_q;
            sel_valid = req_valid[lock_q];
        end else if (elig[0] && elig[1]) begin
            sel       = rr_q;
            sel_valid = 1'b1;
        end else if (elig[0]) begin
            sel_valid = 1'b1;
        end else if (elig[1]) begin
            sel       = 1'b1;
            sel_valid = 1'b1;
        end
    end

    assign a_valid        = sel_valid && !reset;
    assign a_fire         = a_valid && a_ready;
    assign a_first_fire   = a_fire && (state_q == ST_IDLE);
    assign a_bits_opcode  = req_opcode[sel];
    assign a_bits_param   = req_param[sel];
    assign a_bits_size    = req_size[sel];
    assign a_bits_source  = {sel, req_source[sel]};
    assign a_bits_address = req_address[sel];
    assign a_bits_mask    = req_mask[sel];
    assign a_bits_data    = req_data[sel];
    assign gnt            = a_valid ? {sel, ~sel} : 2'b00;
    assign a_multi        = (a_bits_opcode == 3'd0 || a_bits_opcode == 3'd1) && (a_bits_size > BEAT_SIZE);
    assign a_beats_m1     = (BCNT_W'(1) << (a_bits_size - BEAT_SIZE)) - BCNT_W'(1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: if (a_fire) begin
                if (a_multi) begin
                    state_d = ST_LOCK;
                    lock_d  = sel;
                    beat_d  = a_beats_m1;
                end else begin
                    rr_d = ~sel;
                end
            end
            ST_LOCK: if (a_fire) begin
                beat_d = beat_q - BCNT_W'(1);
                if (beat_q == BCNT_W'(1)) begin
                    state_d = ST_IDLE;
                    rr_d    = ~lock_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            lock_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            beat_q  <= beat_d;
        end
    end

    logic              d_idx, d_fire, d_multi;
    logic [BCNT_W-1:0] d_beats_m1;

    assign d_idx      = d_bits_source[SRC_W];
    assign d_ready    = rsp_ready[d_idx] && !reset;
    assign d_fire     = d_valid && d_ready;
    assign d_multi    = (d_bits_opcode == 3'd1) && (d_bits_size > BEAT_SIZE);
    assign d_beats_m1 = (BCNT_W'(1) << (d_bits_size - BEAT_SIZE)) - BCNT_W'(1);

    assign r0_d_bits_opcode  = d_bits_opcode;
    assign r0_d_bits_param   = d_bits_param;
    assign r0_d_bits_size    = d_bits_size;
    assign r0_d_bits_source  = d_bits_source[SRC_W-1:0];
    assign r0_d_bits_sink    = d_bits_sink;
    assign r0_d_bits_denied  = d_bits_denied;
    assign r0_d_bits_corrupt = d_bits_corrupt;
    assign r0_d_bits_data    = d_bits_data;
    assign r1_d_bits_opcode  = d_bits_opcode;
    assign r1_d_bits_param   = d_bits_param;
    assign r1_d_bits_size    = d_bits_size;
    assign r1_d_bits_source  = d_bits_source[SRC_W-1:0];
    assign r1_d_bits_sink    = d_bits_sink;
    assign r1_d_bits_denied  = d_bits_denied;
    assign r1_d_bits_corrupt = d_bits_corrupt;
    assign r1_d_bits_data    = d_bits_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic [OUT_W-1:0]  out_q, out_d;
            logic [BCNT_W-1:0] dbeat_q, dbeat_d;
            logic              d_hit, d_last, inc, dec;

            assign elig[gi]      = req_valid[gi] && (out_q < OUT_W'(MAX_OUTSTANDING));
            assign req_ready[gi] = a_valid && (sel == 1'(gi)) && a_ready;
            assign rsp_valid[gi] = d_valid && (d_idx == 1'(gi)) && !reset;
            assign d_hit         = d_fire && (d_idx == 1'(gi));
            // dbeat_q == 0 means the next D beat starts a new message.
            assign d_last        = d_hit && ((dbeat_q == '0) ? !d_multi : (dbeat_q == BCNT_W'(1)));
            assign inc           = a_first_fire && (sel == 1'(gi));
            assign dec           = d_last;

            always_comb begin
                dbeat_d = dbeat_q;
                out_d   = out_q;
                if (d_hit) begin
                    dbeat_d = (dbeat_q == '0) ? (d_multi ? d_beats_m1 : '0) : dbeat_q - BCNT_W'(1);
                end
                if (inc && !dec && out_q < OUT_W'(MAX_OUTSTANDING)) begin
                    out_d = out_q + OUT_W'(1);
                end else if (dec && !inc && out_q != '0) begin
                    out_d = out_q - OUT_W'(1);
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    out_q   <= '0;
                    dbeat_q <= '0;
                end else begin
                    out_q   <= out_d;
                    dbeat_q <= dbeat_d;
                end
            end

`ifdef TL_ARB_MONITOR_EN
            always_ff @(posedge clock) begin
                if (!reset && inc)
                    $display("[I] ARB grant r%0d op=%0d size=%0d addr=0x%0h", gi, a_bits_opcode, a_bits_size, a_bits_address);
                if (!reset && d_last)
                    $display("[I] ARB resp r%0d op=%0d denied=%0d", gi, d_bits_opcode, d_bits_denied);
                if (!reset && dec && !inc && out_q == '0)
                    $display("[E] ARB r%0d D response with no outstanding request", gi);
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Bench for tl_a_channel_arbiter: directed literal checks, then randomized traffic vs a message-level model.
module tb_tl_a_channel_arbiter;
    localparam int MAXO = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic r0_a_valid, r0_a_ready, r1_a_valid, r1_a_ready;
    logic [2:0] r0_a_bits_opcode, r0_a_bits_param, r1_a_bits_opcode, r1_a_bits_param;
    logic [3:0] r0_a_bits_size, r1_a_bits_size;
    logic [1:0] r0_a_bits_source, r1_a_bits_source;
    logic [31:0] r0_a_bits_address, r1_a_bits_address;
    logic [7:0] r0_a_bits_mask, r1_a_bits_mask;
    logic [63:0] r0_a_bits_data, r1_a_bits_data;
    logic r0_d_valid, r0_d_ready, r1_d_valid, r1_d_ready;
    logic [2:0] r0_d_bits_opcode, r1_d_bits_opcode;
    logic [1:0] r0_d_bits_param, r1_d_bits_param, r0_d_bits_source, r1_d_bits_source;
    logic [3:0] r0_d_bits_size, r1_d_bits_size;
    logic [1:0] r0_d_bits_sink, r1_d_bits_sink;
    logic r0_d_bits_denied, r0_d_bits_corrupt, r1_d_bits_denied, r1_d_bits_corrupt;
    logic [63:0] r0_d_bits_data, r1_d_bits_data;
    logic a_valid, a_ready;
    logic [2:0] a_bits_opcode, a_bits_param, a_bits_source;
    logic [3:0] a_bits_size;
    logic [31:0] a_bits_address;
    logic [7:0] a_bits_mask;
    logic [63:0] a_bits_data;
    logic d_valid, d_ready;
    logic [2:0] d_bits_opcode, d_bits_source;
    logic [1:0] d_bits_param, d_bits_sink;
    logic [3:0] d_bits_size;
    logic d_bits_denied, d_bits_corrupt;
    logic [63:0] d_bits_data;
    logic [1:0] gnt;

    tl_a_channel_arbiter dut (
        .clock(clock), .reset(reset),
        .r0_a_valid(r0_a_valid), .r0_a_ready(r0_a_ready), .r0_a_bits_opcode(r0_a_bits_opcode),
        .r0_a_bits_param(r0_a_bits_param), .r0_a_bits_size(r0_a_bits_size), .r0_a_bits_source(r0_a_bits_source),
        .r0_a_bits_address(r0_a_bits_address), .r0_a_bits_mask(r0_a_bits_mask), .r0_a_bits_data(r0_a_bits_data),
        .r0_d_valid(r0_d_valid), .r0_d_ready(r0_d_ready), .r0_d_bits_opcode(r0_d_bits_opcode),
        .r0_d_bits_param(r0_d_bits_param), .r0_d_bits_size(r0_d_bits_size), .r0_d_bits_source(r0_d_bits_source),
        .r0_d_bits_sink(r0_d_bits_sink), .r0_d_bits_denied(r0_d_bits_denied), .r0_d_bits_corrupt(r0_d_bits_corrupt),
        .r0_d_bits_data(r0_d_bits_data),
        .r1_a_valid(r1_a_valid), .r1_a_ready(r1_a_ready), .r1_a_bits_opcode(r1_a_bits_opcode),
        .r1_a_bits_param(r1_a_bits_param), .r1_a_bits_size(r1_a_bits_size), .r1_a_bits_source(r1_a_bits_source),
        .r1_a_bits_address(r1_a_bits_address), .r1_a_bits_mask(r1_a_bits_mask), .r1_a_bits_data(r1_a_bits_data),
        .r1_d_valid(r1_d_valid), .r1_d_ready(r1_d_ready), .r1_d_bits_opcode(r1_d_bits_opcode),
        .r1_d_bits_param(r1_d_bits_param), .r1_d_bits_size(r1_d_bits_size), .r1_d_bits_source(r1_d_bits_source),
        .r1_d_bits_sink(r1_d_bits_sink), .r1_d_bits_denied(r1_d_bits_denied), .r1_d_bits_corrupt(r1_d_bits_corrupt),
        .r1_d_bits_data(r1_d_bits_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
        .a_bits_size(a_bits_size), .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
        .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
        .d_bits_size(d_bits_size), .d_bits_source(d_bits_source), .d_bits_sink(d_bits_sink),
        .d_bits_denied(d_bits_denied), .d_bits_corrupt(d_bits_corrupt), .d_bits_data(d_bits_data),
        .gnt(gnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [2:0] op, input logic [3:0] sz,
                           input logic [1:0] src, input logic [31:0] addr, input logic [7:0] mask,
                           input logic [63:0] data, input logic [2:0] param);
        if (n == 0) begin
            r0_a_valid = v; r0_a_bits_opcode = op; r0_a_bits_size = sz; r0_a_bits_source = src;
            r0_a_bits_address = addr; r0_a_bits_mask = mask; r0_a_bits_data = data; r0_a_bits_param = param;
        end else begin
            r1_a_valid = v; r1_a_bits_opcode = op; r1_a_bits_size = sz; r1_a_bits_source = src;
            r1_a_bits_address = addr; r1_a_bits_mask = mask; r1_a_bits_data = data; r1_a_bits_param = param;
        end
    endtask

    task automatic clear_inputs();
        set_req(0, 1'b0, 3'd4, 4'd3, 2'd0, 32'h0, 8'hff, 64'h0, 3'd0);
        set_req(1, 1'b0, 3'd4, 4'd3, 2'd0, 32'h0, 8'hff, 64'h0, 3'd0);
        a_ready = 1'b0; d_valid = 1'b0; d_bits_opcode = 3'd0; d_bits_param = 2'd0; d_bits_size = 4'd3;
        d_bits_source = 3'd0; d_bits_sink = 2'd0; d_bits_denied = 1'b0; d_bits_corrupt = 1'b0;
        d_bits_data = 64'h0; r0_d_ready = 1'b0; r1_d_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    typedef struct packed {
        logic [2:0] src;
        logic [2:0] op;
        logic [3:0] size;
    } rsp_t;

    // Randomized requester / responder state and the message-level model.
    logic        gv [2];
    logic [2:0]  gop [2], gparam [2];
    logic [3:0]  gsz [2];
    logic [1:0]  gsrc [2];
    logic [31:0] gaddr [2];
    logic [7:0]  gmask [2];
    logic [63:0] gdata [2];
    int          gleft [2];
    rsp_t        rq [$];
    rsp_t        cur, tmp;
    logic        dv, dnew, e0, e1, ev, exp_dr, afire, dfire;
    int          dleft, pick, sel, k, m_lock, m_left, m_rr, ntxn;
    int          m_out [2];

    initial begin
        clear_inputs();
        // Reset state with active-looking inputs
        reset = 1'b1;
        set_req(0, 1'b1, 3'd4, 4'd3, 2'd0, 32'h10, 8'hff, 64'h1, 3'd0);
        a_ready = 1'b1; d_valid = 1'b1; r0_d_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_r0_a_ready", r0_a_ready, 0);
        chk("rst_r0_d_valid", r0_d_valid, 0);
        chk("rst_d_ready", d_ready, 0);
        tick();
        reset = 1'b0; d_valid = 1'b0;

        // Continuous Gets from both: strict alternation starting at r0
        set_req(0, 1'b1, 3'd4, 4'd3, 2'b10, 32'h100, 8'hff, 64'h0, 3'd0);
        set_req(1, 1'b1, 3'd4, 4'd3, 2'b10, 32'h200, 8'hff, 64'h0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t1_gnt", gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
            chk("t1_src_msb", a_bits_source[2], i % 2);
            $display("t1 beat %0d gnt=%b src=%b", i, gnt, a_bits_source);
            tick();
        end

        // PutFull size=5 from r0 locks the grant for 4 beats
        do_reset();
        set_req(0, 1'b1, 3'd0, 4'd5, 2'b00, 32'h300, 8'hff, 64'h5, 3'd0);
        set_req(1, 1'b1, 3'd4, 4'd3, 2'b01, 32'h400, 8'hff, 64'h0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t2_gnt_lock", gnt, 2'b01);
            chk("t2_r1_blocked", r1_a_ready, 0);
            $display("t2 put beat %0d gnt=%b", i, gnt);
            tick();
        end
        r0_a_valid = 1'b0;
        @(negedge clock);
        chk("t2_r1_after", gnt, 2'b10);
        chk("t2_r1_ready", r1_a_ready, 1);
        tick();

        // Outstanding limit on r0, then one D response unblocks it
        do_reset();
        r1_a_valid = 1'b0;
        set_req(0, 1'b1, 3'd4, 4'd3, 2'b01, 32'h500, 8'hff, 64'h0, 3'd0);
        repeat (4) tick();
        r1_a_valid = 1'b1;
        @(negedge clock);
        chk("t3_r0_stalled", r0_a_ready, 0);
        chk("t3_r1_gnt", gnt, 2'b10);
        tick();
        r1_a_valid = 1'b0;
        d_valid = 1'b1; d_bits_source = 3'b001; d_bits_opcode = 3'd1; d_bits_size = 4'd3;
        d_bits_data = 64'hdead_beef_0000_0001; r0_d_ready = 1'b1;
        @(negedge clock);
        chk("t3_r0_d_valid", r0_d_valid, 1);
        chk("t3_r0_d_src", r0_d_bits_source, 2'b01);
        chk("t3_r0_d_data", r0_d_bits_data, 64'hdead_beef_0000_0001);
        chk("t3_r1_d_valid", r1_d_valid, 0);
        chk("t3_still_stalled", r0_a_ready, 0);
        tick();
        d_valid = 1'b0;
        @(negedge clock);
        chk("t3_r0_unblocked", r0_a_ready, 1);
        tick();

        // D to r1 waits on r1_d_ready
        r0_a_valid = 1'b0;
        d_valid = 1'b1; d_bits_source = 3'b110; d_bits_opcode = 3'd0; d_bits_size = 4'd3;
        r1_d_ready = 1'b0; r0_d_ready = 1'b1;
        @(negedge clock);
        chk("t4_d_ready_low", d_ready, 0);
        chk("t4_r0_d_valid", r0_d_valid, 0);
        chk("t4_r1_d_valid", r1_d_valid, 1);
        chk("t4_r1_d_src", r1_d_bits_source, 2'b10);
        tick();
        r1_d_ready = 1'b1;
        @(negedge clock);
        chk("t4_d_ready_high", d_ready, 1);
        tick();

        // 4-beat AccessAckData to r0 (out0 == 4): release only after last beat
        set_req(0, 1'b1, 3'd4, 4'd3, 2'b00, 32'h600, 8'hff, 64'h0, 3'd0);
        d_valid = 1'b1; d_bits_source = 3'b000; d_bits_opcode = 3'd1; d_bits_size = 4'd5; r0_d_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            chk("t5_blocked_during_burst", r0_a_ready, 0);
            chk("t5_d_valid", r0_d_valid, 1);
            tick();
        end
        d_valid = 1'b0;
        @(negedge clock);
        chk("t5_released", r0_a_ready, 1);
        tick();

        // Reset in the middle of a locked burst
        r0_a_valid = 1'b0;
        do_reset();
        set_req(0, 1'b1, 3'd0, 4'd5, 2'b00, 32'h700, 8'hff, 64'h7, 3'd0);
        set_req(1, 1'b1, 3'd4, 4'd3, 2'b00, 32'h800, 8'hff, 64'h0, 3'd0);
        repeat (2) tick();
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_a_valid", a_valid, 0);
        chk("t6_rst_gnt", gnt, 0);
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 3'd4, 4'd3, 2'b00, 32'h900, 8'hff, 64'h0, 3'd0);
        @(negedge clock);
        chk("t6_r0_wins_tie", gnt, 2'b01);
        tick();

        // Randomized traffic against the message-level model
        clear_inputs();
        do_reset();
        for (int n = 0; n < 2; n++) begin
            gv[n] = 1'b0; gleft[n] = 0; m_out[n] = 0;
            gop[n] = 3'd4; gsz[n] = 4'd0; gsrc[n] = 2'd0; gaddr[n] = 32'd0;
            gmask[n] = 8'd0; gdata[n] = 64'd0; gparam[n] = 3'd0;
        end
        dv = 1'b0; dnew = 1'b1; dleft = 0; m_lock = -1; m_left = 0; m_rr = 0; ntxn = 0;
        cur = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!gv[n] && $urandom_range(2) == 0) begin
                    pick = $urandom_range(2);
                    gop[n] = (pick == 0) ? 3'd4 : (pick == 1) ? 3'd0 : 3'd1;
                    gsz[n] = 4'($urandom_range(5));
                    gsrc[n] = 2'($urandom); gaddr[n] = $urandom; gmask[n] = 8'($urandom);
                    gparam[n] = 3'($urandom); gdata[n] = {$urandom, $urandom};
                    gleft[n] = (gop[n] != 3'd4 && gsz[n] > 4'd3) ? (1 << (gsz[n] - 4'd3)) : 1;
                    gv[n] = 1'b1;
                end
                set_req(n, gv[n], gop[n], gsz[n], gsrc[n], gaddr[n], gmask[n], gdata[n], gparam[n]);
            end
            a_ready = ($urandom_range(3) != 0);
            if (!dv && rq.size() > 0 && $urandom_range(1) == 0) begin
                cur = rq.pop_front();
                dv = 1'b1; dnew = 1'b1;
                dleft = (cur.op == 3'd1 && cur.size > 4'd3) ? (1 << (cur.size - 4'd3)) : 1;
            end
            d_valid = dv; d_bits_source = cur.src; d_bits_opcode = cur.op; d_bits_size = cur.size;
            if (dnew) begin
                d_bits_data = {$urandom, $urandom}; d_bits_param = 2'($urandom); d_bits_sink = 2'($urandom);
                d_bits_denied = 1'($urandom); d_bits_corrupt = 1'($urandom); dnew = 1'b0;
            end
            r0_d_ready = 1'($urandom); r1_d_ready = 1'($urandom);

            @(negedge clock);
            e0 = gv[0] && m_out[0] < MAXO;
            e1 = gv[1] && m_out[1] < MAXO;
            sel = 0; ev = 1'b0;
            if (m_lock >= 0) begin sel = m_lock; ev = gv[sel]; end
            else if (e0 && e1) begin sel = m_rr; ev = 1'b1; end
            else if (e0) begin sel = 0; ev = 1'b1; end
            else if (e1) begin sel = 1; ev = 1'b1; end
            chk("a_valid", a_valid, ev);
            chk("gnt", gnt, ev ? ((sel == 1) ? 2'b10 : 2'b01) : 2'b00);
            chk("r0_a_ready", r0_a_ready, ev && sel == 0 && a_ready);
            chk("r1_a_ready", r1_a_ready, ev && sel == 1 && a_ready);
            if (ev) begin
                chk("a_source", a_bits_source, {1'(sel), gsrc[sel]});
                chk("a_address", a_bits_address, gaddr[sel]);
                chk("a_data", a_bits_data, gdata[sel]);
                chk("a_opcode", a_bits_opcode, gop[sel]);
                chk("a_size", a_bits_size, gsz[sel]);
                chk("a_mask", a_bits_mask, gmask[sel]);
            end
            k = int'(cur.src[2]);
            exp_dr = (k == 1) ? r1_d_ready : r0_d_ready;
            chk("d_ready", d_ready, exp_dr);
            chk("r0_d_valid", r0_d_valid, dv && k == 0);
            chk("r1_d_valid", r1_d_valid, dv && k == 1);
            if (dv) begin
                chk("d_source_route", (k == 1) ? r1_d_bits_source : r0_d_bits_source, cur.src[1:0]);
                chk("d_data_route", (k == 1) ? r1_d_bits_data : r0_d_bits_data, d_bits_data);
                chk("d_denied_route", (k == 1) ? r1_d_bits_denied : r0_d_bits_denied, d_bits_denied);
            end
            afire = ev && a_ready;
            dfire = dv && exp_dr;

            @(posedge clock);
            if (afire) begin
                if (m_lock < 0) begin
                    m_out[sel]++;
                    ntxn++;
                    $display("txn %0d: r%0d op=%0d size=%0d src=%0d addr=0x%0h beats=%0d",
                             ntxn, sel, gop[sel], gsz[sel], gsrc[sel], gaddr[sel], gleft[sel]);
                    if (gleft[sel] > 1) begin m_lock = sel; m_left = gleft[sel] - 1; end
                    else m_rr = 1 - sel;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_lock = -1; m_rr = 1 - sel; end
                end
                gleft[sel]--;
                gdata[sel] = {$urandom, $urandom};
                if (gleft[sel] == 0) begin
                    gv[sel] = 1'b0;
                    tmp.src = {1'(sel), gsrc[sel]};
                    tmp.op = (gop[sel] == 3'd4) ? 3'd1 : 3'd0;
                    tmp.size = gsz[sel];
                    rq.push_back(tmp);
                end
            end
            if (dfire) begin
                dleft--;
                dnew = 1'b1;
                if (dleft == 0) begin
                    dv = 1'b0;
                    if (m_out[k] > 0) m_out[k]--;
                end
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
